// File: rtl/gen_counter_en_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gen_counter_en_pkg
//  Description : Shared helpers for the clock-enable generator. Provides the
//                width function used to size the modulus counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package gen_counter_en_pkg;

    // Bits needed to hold the values 0..n-1. The result is never less than 1,
    // so a modulus of 1 still gets a real (constant-zero) register.
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage : gen_counter_en_pkg
`default_nettype wire

// File: rtl/gen_counter_en.sv
`default_nettype none
// ============================================================================
//  Module      : gen_counter_en
//  Description : Free-running clock-enable generator. Divides clk by SIZE and
//                emits a registered single-cycle strobe once per period, for
//                downstream tick logic to qualify its state updates with.
//  Ports       : clk        - system clock, rising-edge active
//                rst        - asynchronous active-low reset
//                counter_en - registered strobe, high 1 cycle in every SIZE
//  Revision    : 1.0 - initial release
// ============================================================================
module gen_counter_en
    import gen_counter_en_pkg::*;
#(
    parameter int SIZE = 10
) (
    input  logic clk,
    input  logic rst,
    output logic counter_en
);

    localparam int            CW   = cnt_width(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          en_q;
    logic          en_d;
    logic          w_wrap;

    // The wrap is an explicit compare against SIZE-1 rather than relying on
    // natural overflow, so encodings above SIZE-1 can never be entered.
    always_comb begin
        w_wrap = (cnt_q == LAST);
        cnt_d  = w_wrap ? '0 : cnt_q + CW'(1);
        en_d   = w_wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_d;
        end
    end

    // Strobe comes straight from a flop; no combinational path from cnt_q.
    assign counter_en = en_q;

endmodule : gen_counter_en
`default_nettype wire

// File: tb/tb_gen_counter_en.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gen_counter_en
//  Description : Directed self-checking bench for gen_counter_en. Four
//                instances (SIZE = 10, 1, 7, 8) share one clock and reset.
//                After every reset release the k-th rising edge must raise the
//                strobe exactly when k is a multiple of SIZE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_counter_en;

    logic clk;
    logic rst;
    logic w_en10;
    logic w_en1;
    logic w_en7;
    logic w_en8;

    int n_cmp;
    int n_err;

    gen_counter_en #(.SIZE(10)) u10 (.clk(clk), .rst(rst), .counter_en(w_en10));
    gen_counter_en #(.SIZE(1))  u1  (.clk(clk), .rst(rst), .counter_en(w_en1));
    gen_counter_en #(.SIZE(7))  u7  (.clk(clk), .rst(rst), .counter_en(w_en7));
    gen_counter_en #(.SIZE(8))  u8  (.clk(clk), .rst(rst), .counter_en(w_en8));

    // Rising edges at 5, 15, 25, ... ns (10 ns period).
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // All strobes must be low while reset is held.
    task automatic chk_all_low(input string tag);
        chk({tag, "_en10"}, {31'b0, w_en10}, 32'd0);
        chk({tag, "_en1"},  {31'b0, w_en1},  32'd0);
        chk({tag, "_en7"},  {31'b0, w_en7},  32'd0);
        chk({tag, "_en8"},  {31'b0, w_en8},  32'd0);
    endtask

    // Called just after a reset release, before the first post-release edge.
    // Samples 1 ns after each of the next n rising edges. Edge k (1-based)
    // must show a strobe on instance S iff k is a multiple of S. Returns the
    // number of SIZE=10 strobes seen.
    task automatic run_phase(input int n, input string tag, output int s10);
        int last;
        int s7;
        int s8;
        last = -1;
        s10  = 0;
        s7   = 0;
        s8   = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            chk({tag, "_en10"}, {31'b0, w_en10}, (k % 10 == 0) ? 32'd1 : 32'd0);
            chk({tag, "_en1"},  {31'b0, w_en1},  32'd1);
            chk({tag, "_en7"},  {31'b0, w_en7},  (k % 7 == 0) ? 32'd1 : 32'd0);
            chk({tag, "_en8"},  {31'b0, w_en8},  (k % 8 == 0) ? 32'd1 : 32'd0);
            // Non-power-of-two counter must stay inside 0..6.
            chk({tag, "_cnt7_le6"}, {31'b0, (u7.cnt_q <= 3'd6)}, 32'd1);
            if (w_en10) begin
                if (last >= 0) begin
                    chk({tag, "_gap10"}, k - last, 32'd10);
                end
                last = k;
                s10  = s10 + 1;
            end
            if (w_en7) s7 = s7 + 1;
            if (w_en8) s8 = s8 + 1;
        end
        chk({tag, "_cnt_s7"}, s7, n / 7);
        chk({tag, "_cnt_s8"}, s8, n / 8);
    endtask

    // Called 1 ns after a rising edge: pulse reset low for 7 ns, check the
    // asynchronous clear, and release 2 ns before the next rising edge.
    task automatic mid_reset(input string tag);
        rst = 1'b0;
        #1;
        chk_all_low({tag, "_async"});
        chk({tag, "_cnt10"}, {28'b0, u10.cnt_q}, 32'd0);
        #6;
        chk_all_low({tag, "_held"});
        rst = 1'b1;
    endtask

    int strobes;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;

        #1;
        chk_all_low("por");
        #7;  // t=8, after the edge at 5 ns: still held in reset
        chk_all_low("por_edge");
        chk({"por_cnt10"}, {28'b0, u10.cnt_q}, 32'd0);
        #2;  // t=10, release between edges
        rst = 1'b1;

        // Free run: 200 cycles = 20 strobes of the SIZE=10 instance.
        run_phase(200, "run", strobes);
        chk("run_strobes10", strobes, 32'd20);
        chk("run_en10_high", {31'b0, w_en10}, 32'd1);

        // Reset while the SIZE=10 strobe is high.
        mid_reset("rst_hi");

        // Consumer window of 1500 ns.
        run_phase(150, "win1500", strobes);
        chk("win1500_strobes", strobes, 32'd15);

        // Move into the low part of the period, then reset again.
        run_phase(0, "idle", strobes);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_lo_en10", {31'b0, w_en10}, 32'd0);
        mid_reset("rst_lo");

        // Consumer window of 300 ns.
        run_phase(30, "win300", strobes);
        chk("win300_strobes", strobes, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected end before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule : tb_gen_counter_en
`default_nettype wire
